// File: rtl/out_port_display_if.sv
// out_port_display_if: port-data and display-pin bundle
// for the seven-segment scanner.
interface out_port_display_if;
  logic [31:0] value;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (
    output value, blank_lz,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  value, blank_lz,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/out_port_display.sv
// out_port_display: 8-digit multiplexed hex display
// with per-frame snapshot and leading-zero blanking.
module out_port_display #(
  parameter int PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              clr_n,
  out_port_display_if.slave bus
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic          load_pend;

  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic [31:0]   upper;
  logic          blank;
  logic [6:0]    hex;

  // slot timing and the frame-end condition
  always_comb begin
    tick = (cnt == LAST);
    wrap = tick && (idx == 3'd7);
  end

  // pick the current nibble and decide if it is a leading zero
  always_comb begin
    nib   = shadow[{idx, 2'b00} +: 4];
    upper = shadow >> {idx, 2'b00};
    blank = bus.blank_lz && (idx != 3'd0) && (upper == 32'd0);
  end

  // active-low hex segment decode {g,f,e,d,c,b,a}
  always_comb begin
    hex = 7'h7F;
    unique case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
    endcase
  end

  // prescaler, digit index and frame snapshot
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt       <= '0;
      idx       <= 3'd0;
      shadow    <= 32'd0;
      load_pend <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= idx + 3'd1;
      if (load_pend || wrap)
        shadow <= bus.value;
      load_pend <= 1'b0;
    end
  end

  // registered pins; first cycle of each slot is dark to avoid ghosting
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      bus.an         <= 8'hFF;
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.dp         <= 1'b1;
      bus.frame_tick <= wrap;
      if (cnt == '0) begin
        bus.an  <= 8'hFF;
        bus.seg <= 7'h7F;
      end else begin
        bus.an  <= ~(8'b1 << idx);
        bus.seg <= blank ? 7'h7F : hex;
      end
    end
  end

endmodule

// File: tb/tb_out_port_display.sv
// tb_out_port_display: directed checks of scanning,
// blanking, snapshot, reset and PRESCALE=2.
module tb_out_port_display;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   k = 0;
  int   pass = 0;
  int   total = 0;

  out_port_display_if bus4 ();
  out_port_display_if bus2 ();

  out_port_display #(.PRESCALE(4)) u4 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus4.slave)
  );

  out_port_display #(.PRESCALE(2)) u2 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic step_to(input int n);
    while (k < n) step();
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    step();
    step();
    clr_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    bus4.value = 32'h0; bus4.blank_lz = 1'b0;
    bus2.value = 32'h0; bus2.blank_lz = 1'b0;
    clr_n = 1'b0;
    step();
    step();
    total++;
    if ({bus4.an, bus4.seg, bus4.dp, bus4.frame_tick}
        !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      $display("FAIL reset4 an=%h seg=%h dp=%b ft=%b want FF/7F/1/0",
               bus4.an, bus4.seg, bus4.dp, bus4.frame_tick);
    end else pass++;
    total++;
    if ({bus2.an, bus2.seg, bus2.dp, bus2.frame_tick}
        !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      $display("FAIL reset2 an=%h seg=%h dp=%b ft=%b want FF/7F/1/0",
               bus2.an, bus2.seg, bus2.dp, bus2.frame_tick);
    end else pass++;
  endtask

  task automatic test_scan();
    int pulses;
    int last;
    bus4.value = 32'h12345678;
    bus4.blank_lz = 1'b0;
    do_reset();
    step();
    total++;
    if ({bus4.an, bus4.seg} !== {8'hFF, 7'h7F}) begin
      $display("FAIL scan_first_off an=%h seg=%h want FF/7F",
               bus4.an, bus4.seg);
    end else pass++;
    for (int j = 2; j <= 4; j++) begin
      step();
      total++;
      if ({bus4.an, bus4.seg} !== {8'hFE, 7'h00}) begin
        $display("FAIL scan_d0 k=%0d an=%h seg=%h want FE/00",
                 k, bus4.an, bus4.seg);
      end else pass++;
    end
    step();
    total++;
    if ({bus4.an, bus4.seg} !== {8'hFF, 7'h7F}) begin
      $display("FAIL scan_d1_off an=%h seg=%h want FF/7F",
               bus4.an, bus4.seg);
    end else pass++;
    step_to(29);
    total++;
    if ({bus4.an, bus4.seg} !== {8'hFF, 7'h7F}) begin
      $display("FAIL scan_d7_off an=%h seg=%h want FF/7F",
               bus4.an, bus4.seg);
    end else pass++;
    step_to(30);
    total++;
    if ({bus4.an, bus4.seg} !== {8'h7F, 7'h79}) begin
      $display("FAIL scan_d7 an=%h seg=%h want 7F/79",
               bus4.an, bus4.seg);
    end else pass++;
    step_to(31);
    total++;
    if (bus4.frame_tick !== 1'b0) begin
      $display("FAIL scan_ft_early ft=%b want 0", bus4.frame_tick);
    end else pass++;
    step_to(32);
    total++;
    if (bus4.frame_tick !== 1'b1) begin
      $display("FAIL scan_ft32 ft=%b want 1", bus4.frame_tick);
    end else pass++;
    pulses = 0;
    last = 0;
    while (k < 64) begin
      step();
      if (bus4.frame_tick === 1'b1) begin
        pulses++;
        last = k;
      end
    end
    total++;
    if (pulses != 1 || last != 64) begin
      $display("FAIL scan_ft_period pulses=%0d at k=%0d want 1 at 64",
               pulses, last);
    end else pass++;
  endtask

  task automatic test_blank();
    logic [6:0] exp_a5 [8];
    logic [6:0] exp_z  [8];
    logic [7:0] an_e;
    exp_a5 = '{7'h12, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    exp_z  = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    bus4.value = 32'h000000A5;
    bus4.blank_lz = 1'b1;
    do_reset();
    for (int d = 0; d < 8; d++) begin
      step_to(4 * d + 2);
      an_e = ~(8'b1 << d);
      total++;
      if ({bus4.an, bus4.seg} !== {an_e, exp_a5[d]}) begin
        $display("FAIL blank_a5 d=%0d an=%h seg=%h want %h/%h",
                 d, bus4.an, bus4.seg, an_e, exp_a5[d]);
      end else pass++;
    end
    bus4.value = 32'h0;
    do_reset();
    for (int d = 0; d < 8; d++) begin
      step_to(4 * d + 3);
      an_e = ~(8'b1 << d);
      total++;
      if ({bus4.an, bus4.seg} !== {an_e, exp_z[d]}) begin
        $display("FAIL blank_zero d=%0d an=%h seg=%h want %h/%h",
                 d, bus4.an, bus4.seg, an_e, exp_z[d]);
      end else pass++;
    end
    bus4.blank_lz = 1'b0;
  endtask

  task automatic test_anti_tear();
    logic [7:0] an_e;
    bus4.value = 32'h11111111;
    bus4.blank_lz = 1'b0;
    do_reset();
    step_to(14);
    bus4.value = 32'h22222222;
    step_to(18);
    total++;
    if ({bus4.an, bus4.seg} !== {8'hEF, 7'h79}) begin
      $display("FAIL tear_d4 an=%h seg=%h want EF/79",
               bus4.an, bus4.seg);
    end else pass++;
    step_to(32);
    total++;
    if ({bus4.an, bus4.seg, bus4.frame_tick} !== {8'h7F, 7'h79, 1'b1}) begin
      $display("FAIL tear_d7 an=%h seg=%h ft=%b want 7F/79/1",
               bus4.an, bus4.seg, bus4.frame_tick);
    end else pass++;
    for (int d = 0; d < 8; d++) begin
      step_to(4 * d + 34);
      an_e = ~(8'b1 << d);
      total++;
      if ({bus4.an, bus4.seg} !== {an_e, 7'h24}) begin
        $display("FAIL tear_new d=%0d an=%h seg=%h want %h/24",
                 d, bus4.an, bus4.seg, an_e);
      end else pass++;
    end
  endtask

  task automatic test_reset_mid();
    bus4.value = 32'h12345678;
    bus4.blank_lz = 1'b0;
    do_reset();
    step_to(22);
    clr_n = 1'b0;
    step();
    total++;
    if ({bus4.an, bus4.seg, bus4.frame_tick} !== {8'hFF, 7'h7F, 1'b0}) begin
      $display("FAIL rstmid an=%h seg=%h ft=%b want FF/7F/0",
               bus4.an, bus4.seg, bus4.frame_tick);
    end else pass++;
    bus4.value = 32'hF;
    step();
    clr_n = 1'b1;
    k = 0;
    step();
    total++;
    if ({bus4.an, bus4.seg} !== {8'hFF, 7'h7F}) begin
      $display("FAIL rstmid_e1 an=%h seg=%h want FF/7F",
               bus4.an, bus4.seg);
    end else pass++;
    step();
    total++;
    if ({bus4.an, bus4.seg} !== {8'hFE, 7'h0E}) begin
      $display("FAIL rstmid_e2 an=%h seg=%h want FE/0E",
               bus4.an, bus4.seg);
    end else pass++;
    do_reset();
    step_to(31);
    clr_n = 1'b0;
    step();
    total++;
    if ({bus4.an, bus4.frame_tick} !== {8'hFF, 1'b0}) begin
      $display("FAIL rst_at_wrap an=%h ft=%b want FF/0",
               bus4.an, bus4.frame_tick);
    end else pass++;
  endtask

  task automatic test_prescale2();
    int pulses;
    int last;
    bus2.value = 32'h12345678;
    bus2.blank_lz = 1'b0;
    do_reset();
    step();
    total++;
    if ({bus2.an, bus2.seg} !== {8'hFF, 7'h7F}) begin
      $display("FAIL p2_k1 an=%h seg=%h want FF/7F", bus2.an, bus2.seg);
    end else pass++;
    step();
    total++;
    if ({bus2.an, bus2.seg} !== {8'hFE, 7'h00}) begin
      $display("FAIL p2_k2 an=%h seg=%h want FE/00", bus2.an, bus2.seg);
    end else pass++;
    step();
    total++;
    if ({bus2.an, bus2.seg} !== {8'hFF, 7'h7F}) begin
      $display("FAIL p2_k3 an=%h seg=%h want FF/7F", bus2.an, bus2.seg);
    end else pass++;
    step();
    total++;
    if ({bus2.an, bus2.seg} !== {8'hFD, 7'h78}) begin
      $display("FAIL p2_k4 an=%h seg=%h want FD/78", bus2.an, bus2.seg);
    end else pass++;
    step_to(16);
    total++;
    if ({bus2.an, bus2.seg, bus2.frame_tick} !== {8'h7F, 7'h79, 1'b1}) begin
      $display("FAIL p2_k16 an=%h seg=%h ft=%b want 7F/79/1",
               bus2.an, bus2.seg, bus2.frame_tick);
    end else pass++;
    pulses = 0;
    last = 0;
    while (k < 32) begin
      step();
      if (bus2.frame_tick === 1'b1) begin
        pulses++;
        last = k;
      end
    end
    total++;
    if (pulses != 1 || last != 32) begin
      $display("FAIL p2_ft_period pulses=%0d at k=%0d want 1 at 32",
               pulses, last);
    end else pass++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_anti_tear();
    test_reset_mid();
    test_prescale2();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/out_port_display.md
# out_port_display

Scans the 32-bit value latched by the CPU output port onto an 8-digit, common-anode, multiplexed seven-segment display as hexadecimal. It sits directly downstream of the output port register and is fed by its Q bus; its outputs drive board pins. It holds a per-frame snapshot so a digit set never mixes old and new port values. It can also blank leading zeros.

## Interface
- PRESCALE, default 50000: clock cycles per digit slot. Must be ≥ 2.
- clk  in  1: system clock; all state changes on its rising edge.
- clr_n  in  1: reset, synchronous and active-low, sampled on the rising edge of clk.
- value  in  32: output-port data, nibble i shown on digit i (digit 0 = bits 3:0, rightmost).
- blank_lz  in  1: 1 = blank leading-zero digits.
- an  out  8: digit anodes, active-low, one-hot when lit.
- seg  out  7: segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1: decimal point, active-low; held 1 (off) at all times.
- frame_tick  out  1: one-cycle pulse on each frame completion.

## Operation
- State:
  - cnt: prescaler, 0..PRESCALE-1.
  - idx[2:0]: current digit.
  - shadow[31:0]: frame snapshot.
  - load_pend: 1-bit flag.
  - All outputs are registered.
- Reset (clr_n=0 at an edge):
  - cnt=0, idx=0, shadow=0, load_pend=1.
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
- Prescaler: each active edge, cnt increments. At PRESCALE-1 it wraps to 0 and asserts an internal tick.
- Digit advance: on tick, idx increments, wrapping from 7 to 0.
- Snapshot load: shadow <= value when either condition holds at the edge (else shadow holds):
  - load_pend=1; load_pend then clears.
  - tick with idx==7.
- frame_tick: registered to 1 on the edge where tick and idx==7; otherwise 0.
- Output register, computed from pre-edge state:
  - If cnt==0 (ghost guard, first cycle of every slot): an<=8'hFF, seg<=7'h7F.
  - Otherwise: an<=~(8'b1<<idx). seg<=7'h7F if digit idx is blanked, else seg<=hex(shadow[4*idx+3:4*idx]).
- Blanking: digit i is blanked iff blank_lz=1, i≠0, and shadow[31:4*i]==0. Digit 0 is never blanked. Anodes still scan during a blanked slot.
- hex() map (active-low):
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- blank_lz is sampled live each cycle, not snapshotted.

## Timing
- Slot = PRESCALE cycles. The lit portion is PRESCALE-1 cycles, preceded by 1 all-off cycle.
- Frame = 8·PRESCALE cycles.
- Output latency: one cycle after the state it reflects.
- First active edge after reset:
  - shadow loads value.
  - Outputs are off, because cnt==0.
  - Digit 0 lights on the 2nd active edge, showing the reloaded shadow.
- A value change mid-frame is invisible until the edge that pulses frame_tick; all 8 digits of the next frame use the new value.
- Reset mid-frame: the next edge forces the reset state regardless of cnt, idx or tick. No frame_tick is emitted.

## Test plan
- PRESCALE=4, value=0x12345678, blank_lz=0:
  - digit 0 slot: an=FE, seg=00 ("8"), for 3 cycles after 1 cycle of FF/7F.
  - digit 7 slot: an=7F, seg=79 ("1").
  - frame_tick every 32 cycles.
- Leading zeros:
  - value=0x000000A5, blank_lz=1: digits 2–7 give seg=7F with an still low; digit 1 seg=08; digit 0 seg=12.
  - value=0, blank_lz=1: digit 0 seg=40, all others 7F.
- Anti-tear:
  - Change value 0x11111111 → 0x22222222 during the idx=3 slot.
  - Digits 4–7 still show 79.
  - From the frame_tick edge on, all digits show 24.
- Reset mid-frame:
  - Drop clr_n during the idx=5 slot: next edge gives an=FF, seg=7F, frame_tick=0.
  - Release with value=0xF: the 2nd active edge gives an=FE, seg=0E.
- Boundary PRESCALE=2: slots alternate 1 off-cycle and 1 lit cycle, and frame_tick period is 16 cycles.
